// File: rtl/simple_cpu_if.sv
// Program-load and debug-observation bundle for simple_cpu.
// CPU_FLAG_PORTS_EN adds flag_n/flag_z/flag_v mirrors of the internal flags.
interface simple_cpu_if;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       instr_valid;
  logic [7:0] instr;
  logic [3:0] pc;
  logic [7:0] reg_a;
  logic [7:0] reg_b;
  logic [7:0] reg_c;
  logic [7:0] reg_d;
  logic       halted;
`ifdef CPU_FLAG_PORTS_EN
  logic       flag_n;
  logic       flag_z;
  logic       flag_v;

  modport master (
    output prog_we, prog_addr, prog_data,
    input  instr_valid, instr, pc, reg_a, reg_b, reg_c, reg_d, halted, flag_n, flag_z, flag_v
  );
  modport slave (
    input  prog_we, prog_addr, prog_data,
    output instr_valid, instr, pc, reg_a, reg_b, reg_c, reg_d, halted, flag_n, flag_z, flag_v
  );
`else
  modport master (
    output prog_we, prog_addr, prog_data,
    input  instr_valid, instr, pc, reg_a, reg_b, reg_c, reg_d, halted
  );
  modport slave (
    input  prog_we, prog_addr, prog_data,
    output instr_valid, instr, pc, reg_a, reg_b, reg_c, reg_d, halted
  );
`endif
endinterface

// File: rtl/simple_cpu.sv
// Two-cycle-per-instruction 8-bit CPU with 16x8 unified memory and registers A-D.
// Optional macro CPU_FLAG_PORTS_EN exposes the N/Z/V flags on the interface.
module simple_cpu #(
  parameter int unsigned MEM_DEPTH = 16,
  parameter int unsigned DATA_W    = 8
) (
  input logic         clk,
  input logic         rst_n,
  simple_cpu_if.slave bus
);

  typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [3:0]        pc_int_q, pc_int_d, pc_q, pc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] regs_q [4];
  logic [DATA_W-1:0] regs_d [4];
  logic              flag_n_q, flag_n_d, flag_z_q, flag_z_d, flag_v_q, flag_v_d;
  logic              mem_we;
  logic [3:0]        opcode, operand;
  logic [1:0]        rx, ry;
  logic [DATA_W-1:0] alu_x, alu_y, alu_res;
  logic              alu_v;

  assign opcode  = instr_q[7:4];
  assign operand = instr_q[3:0];
  assign rx      = operand[3:2];
  assign ry      = operand[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StFetch;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: state_d = StExec;
      StExec:  state_d = (opcode == 4'b0001) ? StHalt : StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    bus.instr_valid = (state_q == StExec);
    bus.halted      = (state_q == StHalt);
  end

  // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
  always_comb begin
    alu_x   = regs_q[rx];
    alu_y   = regs_q[ry];
    alu_res = '0;
    alu_v   = 1'b0;
    unique case (opcode[1:0])
      2'b00: begin
        alu_res = alu_x + alu_y;
        alu_v   = (alu_x[7] == alu_y[7]) && (alu_res[7] != alu_x[7]);
      end
      2'b01: begin
        alu_res = alu_x - alu_y;
        alu_v   = (alu_x[7] != alu_y[7]) && (alu_res[7] != alu_x[7]);
      end
      2'b10:   alu_res = alu_x & alu_y;
      default: alu_res = alu_x | alu_y;
    endcase
  end

  always_comb begin
    pc_int_d = pc_int_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    regs_d   = regs_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    flag_v_d = flag_v_q;
    mem_we   = 1'b0;
    case (state_q)
      StFetch: begin
        instr_d  = mem[pc_int_q];
        pc_d     = pc_int_q;
        pc_int_d = pc_int_q + 4'd1;
      end
      StExec: begin
        case (opcode[3:2])
          2'b00: begin
            if (opcode[1:0] == 2'b10 || (opcode[1:0] == 2'b11 && flag_n_q)) pc_int_d = operand;
          end
          2'b01: regs_d[opcode[1:0]] = mem[operand];
          2'b10: mem_we = 1'b1;
          default: begin
            regs_d[rx] = alu_res;
            flag_n_d   = alu_res[7];
            flag_z_d   = (alu_res == '0);
            flag_v_d   = alu_v;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_int_q <= '0;
      pc_q     <= '0;
      instr_q  <= '0;
      regs_q   <= '{default: '0};
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else begin
      pc_int_q <= pc_int_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      regs_q   <= regs_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
      flag_v_q <= flag_v_d;
    end
  end

  // Memory survives reset; the program port is only live while reset is held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
    end else if (mem_we) begin
      mem[operand] <= regs_q[opcode[1:0]];
    end
  end

  assign bus.instr = instr_q;
  assign bus.pc    = pc_q;
  assign bus.reg_a = regs_q[0];
  assign bus.reg_b = regs_q[1];
  assign bus.reg_c = regs_q[2];
  assign bus.reg_d = regs_q[3];
`ifdef CPU_FLAG_PORTS_EN
  assign bus.flag_n = flag_n_q;
  assign bus.flag_z = flag_z_q;
  assign bus.flag_v = flag_v_q;
`endif

endmodule

// File: tb/tb_simple_cpu.sv
// Bench for simple_cpu: directed and random programs checked against an ISA-level model.
module tb_simple_cpu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  simple_cpu_if bus();

  simple_cpu u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit [7:0] prog [16];
  bit [7:0] m_mem [16];
  int       m_reg [4];
  int       m_pc, m_fetch_pc;
  bit       m_n, m_z, m_v, m_halt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags();
`ifdef CPU_FLAG_PORTS_EN
    chk("flag_n", bus.flag_n, m_n);
    chk("flag_z", bus.flag_z, m_z);
    chk("flag_v", bus.flag_v, m_v);
`endif
  endtask

  // Architectural interpreter: one whole instruction per call.
  task automatic model_step();
    int ins, op, a, x, y, sx, sy, r;
    ins        = m_mem[m_pc];
    m_fetch_pc = m_pc;
    m_pc       = (m_pc + 1) % 16;
    op         = ins / 16;
    a          = ins % 16;
    if (op == 1) m_halt = 1'b1;
    else if (op == 2) m_pc = a;
    else if (op == 3) begin
      if (m_n) m_pc = a;
    end else if (op >= 4 && op < 8) m_reg[op - 4] = m_mem[a];
    else if (op >= 8 && op < 12) m_mem[a] = 8'(m_reg[op - 8]);
    else if (op >= 12) begin
      x  = m_reg[a / 4];
      y  = m_reg[a % 4];
      sx = (x > 127) ? x - 256 : x;
      sy = (y > 127) ? y - 256 : y;
      case (op)
        12:      r = sx + sy;
        13:      r = sx - sy;
        14:      r = x & y;
        default: r = x | y;
      endcase
      m_v = (op < 14) && (r > 127 || r < -128);
      r   = r & 255;
      m_reg[a / 4] = r;
      m_n = (r >= 128);
      m_z = (r == 0);
    end
  endtask

  task automatic load_reset(input bit do_prog);
    rst_n = 1'b0;
    if (do_prog) begin
      for (int i = 0; i < 16; i++) begin
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'(i);
        bus.prog_data = prog[i];
        m_mem[i]      = prog[i];
        tick();
      end
    end
    bus.prog_we = 1'b0;
    tick();
    chk("rst_pc", bus.pc, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_regs", {bus.reg_a, bus.reg_b, bus.reg_c, bus.reg_d}, 0);
    m_pc = 0;
    m_n = 1'b0; m_z = 1'b0; m_v = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    chk_flags();
    rst_n = 1'b1;
  endtask

  task automatic run_prog(input int max_ins);
    for (int n = 0; n < max_ins && !m_halt; n++) begin
      tick();
      chk("fetch_valid", bus.instr_valid, 1);
      chk("fetch_pc", bus.pc, m_pc);
      chk("fetch_instr", bus.instr, m_mem[m_pc]);
      model_step();
      tick();
      chk("exec_valid", bus.instr_valid, 0);
      chk("reg_a", bus.reg_a, m_reg[0]);
      chk("reg_b", bus.reg_b, m_reg[1]);
      chk("reg_c", bus.reg_c, m_reg[2]);
      chk("reg_d", bus.reg_d, m_reg[3]);
      chk("halted", bus.halted, m_halt);
      chk_flags();
    end
    if (m_halt) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("hold_valid", bus.instr_valid, 0);
        chk("hold_halted", bus.halted, 1);
        chk("hold_pc", bus.pc, m_fetch_pc);
      end
    end
  endtask

  task automatic fill(input bit [7:0] v);
    for (int i = 0; i < 16; i++) prog[i] = v;
  endtask

  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;

    // HALT at address 0
    fill(8'h00); prog[0] = 8'h10;
    load_reset(1'b1);
    run_prog(4);

    // READ/ADD/LOAD, read back the stored word through C
    fill(8'h00);
    prog[0] = 8'h4E; prog[1] = 8'h5F; prog[2] = 8'hC1; prog[3] = 8'h8D;
    prog[4] = 8'h6D; prog[5] = 8'h10; prog[14] = 8'h05; prog[15] = 8'h03;
    load_reset(1'b1);
    run_prog(10);

    // SUB negative then JUMP_NEG taken (A=1), then not taken (A=3)
    fill(8'h00);
    prog[0] = 8'h4E; prog[1] = 8'h5F; prog[2] = 8'hD1; prog[3] = 8'h39;
    prog[4] = 8'h10; prog[9] = 8'h10; prog[14] = 8'h01; prog[15] = 8'h02;
    load_reset(1'b1);
    run_prog(10);
    prog[14] = 8'h03;
    load_reset(1'b1);
    run_prog(10);

    // Overflow, SUB A,A zero, AND clearing V, JUMP_NEG sensing N
    fill(8'h00);
    prog[0] = 8'h4E; prog[1] = 8'h5F; prog[2] = 8'hC1; prog[3] = 8'h36;
    prog[4] = 8'h10; prog[6] = 8'hD0; prog[7] = 8'hC1; prog[8] = 8'hE1;
    prog[9] = 8'h10; prog[14] = 8'h7F; prog[15] = 8'h01;
    load_reset(1'b1);
    run_prog(12);

    // PC wrap to HALT at 15, then JUMP 0 at 15
    fill(8'h00); prog[15] = 8'h10;
    load_reset(1'b1);
    run_prog(20);
    prog[15] = 8'h20;
    load_reset(1'b1);
    run_prog(18);

    // Self-modifying: store HALT into the very next instruction
    fill(8'h00);
    prog[0] = 8'h4E; prog[1] = 8'h82; prog[2] = 8'h00; prog[3] = 8'h7E;
    prog[14] = 8'h10;
    load_reset(1'b1);
    run_prog(8);

    // Reset during EXEC of READ_C, then restart from unchanged memory
    fill(8'h00);
    prog[0] = 8'h4E; prog[1] = 8'h6F; prog[2] = 8'hC8; prog[3] = 8'hAC;
    prog[4] = 8'h7C; prog[5] = 8'h10; prog[14] = 8'h11; prog[15] = 8'h5A;
    load_reset(1'b1);
    run_prog(1);
    tick();
    chk("mid_instr", bus.instr, 8'h6F);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_c", bus.reg_c, 0);
    chk("mid_rst_a", bus.reg_a, 0);
    chk("mid_rst_pc", bus.pc, 0);
    load_reset(1'b0);
    run_prog(10);

    // Random programs
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
      if (k % 2 == 0) prog[15] = 8'h10;
      load_reset(1'b1);
      run_prog(24);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/simple_cpu.md
Name: simple_cpu

Overview:
- Minimal 8-bit accumulator-less CPU with 16x8 unified instruction/data memory, four 8-bit registers A–D, 4-bit program counter and N/Z/V flags.
- Fetches one 8-bit instruction per instruction cycle: opcode[7:4], operand[3:0].
- Runs from memory address 0 after reset until HALT.
- Top-level compute block; the bench preloads memory through the program port and observes the debug outputs.

Parameters:
- MEM_DEPTH, 16, memory words (fixed; address width 4)
- DATA_W, 8, word and register width (fixed)

Ports:
- clk  in  1  single system clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- prog_we  in  1  memory program write strobe, honoured only while rst_n=0
- prog_addr  in  4  program write address
- prog_data  in  8  program write data
- instr_valid  out  1  one-cycle pulse: a new instruction has been fetched into instr
- instr  out  8  instruction register contents
- pc  out  4  address of the instruction currently in instr
- reg_a, reg_b, reg_c, reg_d  out  8 each  register file contents
- halted  out  1  high once HALT has executed

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pc=0, instr=0, all registers=0, flags=0, halted=0, instr_valid=0, FSM goes to FETCH.
  - Memory is NOT cleared. prog_we writes mem[prog_addr]<=prog_data during reset only.
- FSM states: FETCH, EXEC, HALT_ST.
- FETCH (1 cycle):
  - instr<=mem[pc_int], pc<=pc_int, pc_int<=pc_int+1 (wraps 15->0).
  - Next state EXEC; instr_valid=1 during the following (EXEC) cycle.
- EXEC (1 cycle): executes instr, then returns to FETCH. Each instruction takes exactly 2 cycles.
- Opcodes (a = operand[3:0]; rx = operand[3:2], ry = operand[1:0], with 00=A, 01=B, 10=C, 11=D):
  - 0000 NOP: no effect.
  - 0001 HALT: go to HALT_ST; halted=1. HALT_ST is held until reset, with no further fetches and no memory or register writes.
  - 0010 JUMP a: pc_int<=a.
  - 0011 JUMP_NEG a: pc_int<=a if flag N=1, else sequential.
  - 0100–0111 READ_A..READ_D a: the selected register <= mem[a].
  - 1000–1011 LOAD_A..LOAD_D a: mem[a] <= the selected register.
  - 1100 ADD rx,ry: rx<=rx+ry (mod 256).
  - 1101 SUB rx,ry: rx<=rx-ry (mod 256).
  - 1110 AND rx,ry: rx<=rx&ry.
  - 1111 OR rx,ry: rx<=rx|ry.
- Flags:
  - Updated only by ALU ops (1100–1111).
  - N=result[7]; Z=(result==0).
  - V: two's-complement signed overflow for ADD/SUB; cleared by AND/OR.
  - Flags are held by all other instructions.
- Self-modifying code is legal:
  - A LOAD into an address is visible to any later fetch.
  - LOAD to the address of the next instruction takes effect for that fetch.
- rx==ry is legal; e.g. SUB A,A gives 0 and Z=1.
- Reset asserted mid-instruction aborts it; no partial write survives.
- pc output shows the address of the instruction in instr. After JUMP, the next instr_valid shows pc equal to the target.

Optional Feature:
- Macro CPU_FLAG_PORTS_EN.
- When defined: adds outputs flag_n, flag_z, flag_v (1 bit each, reset 0) mirroring the internal flags.
- When undefined: flags stay internal only; function is identical.

Test Plan:
- Load mem[0]=0001_0000 (HALT) and release reset. Expect one instr_valid with pc=0, instr=0x10, halted=1 by cycle 2, and no further instr_valid.
- Program:
  - mem: 0:READ_A 14, 1:READ_B 15, 2:ADD A,B (0xC1), 3:LOAD_A 13, 4:HALT; mem14=0x05, mem15=0x03.
  - Expect A=0x08, B=0x03, mem13=0x08, N=Z=V=0, halt at pc=4.
- SUB producing a negative result, then JUMP_NEG:
  - A=0x01, B=0x02; SUB A,B gives A=0xFF, N=1.
  - JUMP_NEG 9 is taken: next fetch pc=9.
  - With A=0x03 instead, JUMP_NEG is not taken and pc continues sequentially.
- Overflow/zero:
  - ADD with 0x7F+0x01 gives 0x80, V=1, N=1.
  - SUB A,A gives 0x00, Z=1, V=0.
  - A following AND clears V.
- PC wrap: NOPs at addresses 0–14 and HALT at address 15. Expect pc to go 0..15 sequentially, then halt; a JUMP 0 at 15 instead shows pc=0 on the next fetch.
- Reset mid-run: assert rst_n=0 during an EXEC of READ_C. Registers and pc must read 0 on the next cycle, memory contents are unchanged, and the program restarts at address 0 after release.
